x7408_padseq: RTL and testbench
===============================

X7408_PADSEQ -- requirements
Module: x7408_padseq

Interface
REQ-001 SHALL have parameter NPADS, default 12, giving the number of GPIO pads sequenced (4 sides x 3).
REQ-002 SHALL have parameter CFGW, default 8, giving the per-pad cfg width.
REQ-003 SHALL have parameter STAGGER, default 4, giving the cycles between successive pad enable/disable steps (legal range >= 1).
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  single clock, all state rising-edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 start  in  1  pulse: begin enable sequence.
REQ-008 stop  in  1  pulse: begin disable sequence.
REQ-009 dir_mask  in  NPADS  per pad: 1 = output, 0 = input; sampled on accepted start.
REQ-010 wr_valid  in  1  cfg write request.
REQ-011 wr_ready  out  1  cfg write accepted when valid&ready.
REQ-012 wr_addr  in  4  pad index of the write.
REQ-013 wr_data  in  CFGW  cfg value of the write.
REQ-014 pad_ie  out  NPADS  per-pad input enable.
REQ-015 pad_oen  out  NPADS  per-pad output enable, active-low.
REQ-016 pad_cfg  out  NPADS*CFGW  per-pad cfg; pad i occupies bits [i*CFGW +: CFGW].
REQ-017 busy  out  1  high in SEQ_ON or SEQ_OFF.
REQ-018 done  out  1  high in ON.

Function
REQ-019 SHALL implement states IDLE, SEQ_ON, ON, SEQ_OFF.
REQ-020 IDLE + start SHALL register dir_mask, go to SEQ_ON, and enable pad 0 on the next edge.
REQ-021 In SEQ_ON, pad k SHALL be enabled exactly k*STAGGER cycles after pad 0.
REQ-022 One cycle after pad NPADS-1 is enabled, the block SHALL go to ON.
REQ-023 Enabling pad i SHALL set pad_ie[i] = ~dir[i] and pad_oen[i] = ~dir[i]; a disabled pad SHALL have ie=0 and oen=1.
REQ-024 pad_cfg for an enabled pad SHALL equal its cfg register; for a disabled pad it SHALL be 0.
REQ-025 ON + stop SHALL go to SEQ_OFF and disable pad NPADS-1 on the next edge, then descending indices every STAGGER cycles.
REQ-026 One cycle after pad 0 is disabled, the block SHALL go to IDLE.
REQ-027 stop during SEQ_ON SHALL abort the enable sequence: go to SEQ_OFF, disable the highest enabled pad on the next edge, then continue descending.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 stop in IDLE or SEQ_OFF SHALL be ignored.
REQ-030 start and stop asserted together in IDLE: start SHALL win; in ON: stop SHALL win.
REQ-031 wr_ready SHALL be 1 only in IDLE and ON.
REQ-032 An accepted write SHALL update the cfg register the next cycle, and SHALL be visible on pad_cfg the next cycle if that pad is enabled.
REQ-033 A write with wr_addr >= NPADS SHALL be accepted and discarded.
REQ-034 The stagger counter SHALL be CLOG2(STAGGER) bits wide and reload on each step; the pad index SHALL saturate at 0 or NPADS-1 and never wrap.
REQ-035 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs except wr_ready, which is a function of state only.

Reset
REQ-036 Reset SHALL force state IDLE, pad_ie=0, pad_oen=all ones, pad_cfg=0, all cfg registers=0, dir register=0, counters=0, busy=0, done=0.
REQ-037 Reset asserted mid-sequence SHALL immediately return all pads to the disabled level with no staggering.

Structure
REQ-038 Package x7408_padseq_pkg SHALL hold the state enum and the default values of NPADS, CFGW and STAGGER.
REQ-039 The cfg register file with its write port SHALL be the sub-module x7408_padseq_regfile (NPADS x CFGW, one write port, flat read bus).

Verification
REQ-040 Test: reset then idle. Required: pad_oen=0xFFF, pad_ie=0, pad_cfg=0, busy=0, done=0, wr_ready=1.
REQ-041 Test: write pad 3 = 0xA5, dir_mask=0x00F, start at cycle 0. Required: pad0 enabled at cycle 1, pad11 at cycle 45, done at 46, pad_oen=0xFF0, pad_ie=0xFF0, pad_cfg[3]=0xA5.
REQ-042 Test: stop in ON at cycle 0. Required: pad11 disabled at cycle 1, pad0 at 45, busy low and IDLE at 46.
REQ-043 Test: stop at cycle 10 of SEQ_ON, when pads 0..2 are enabled. Required: pad2 disabled at cycle 11, pad0 at 19, IDLE at 20.
REQ-044 Test: write addr 13 in IDLE, and wr_valid during SEQ_ON. Required: first write accepted with no register change; second sees wr_ready=0.
REQ-045 Test: reset asserted mid-SEQ_ON. Required: the same cycle, all outputs return to REQ-036 values.

Source files
------------

// File: rtl/x7408_padseq_pkg.sv
// x7408_padseq_pkg: sequencer state encoding and default geometry of the pad ring
package x7408_padseq_pkg;
  typedef enum logic [1:0] {IDLE, SEQ_ON, ON, SEQ_OFF} state_t;
  localparam int NPADS_DEF = 12;
  localparam int CFGW_DEF = 8;
  localparam int STAGGER_DEF = 4;
endpackage

// File: rtl/x7408_padseq_regfile.sv
// x7408_padseq_regfile: per-pad cfg registers, one write port, flat read bus
module x7408_padseq_regfile
  import x7408_padseq_pkg::*;
#(
  parameter int NPADS = NPADS_DEF,
  parameter int CFGW = CFGW_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [3:0]            i_addr,
  input  logic [CFGW-1:0]       i_data,
  output logic [NPADS*CFGW-1:0] o_rdata
);
  logic [NPADS*CFGW-1:0] r_mem;
  // addresses at or beyond NPADS match no slot and fall away
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_mem <= '0;
    else for (int i = 0; i < NPADS; i++) if (i_we && i_addr == 4'(i)) r_mem[i*CFGW +: CFGW] <= i_data;
  assign o_rdata = r_mem;
endmodule

// File: rtl/x7408_padseq.sv
// x7408_padseq: staggered power-up/power-down sequencer for the GPIO pad ring
module x7408_padseq
  import x7408_padseq_pkg::*;
#(
  parameter int NPADS = NPADS_DEF,
  parameter int CFGW = CFGW_DEF,
  parameter int STAGGER = STAGGER_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [NPADS-1:0]      i_dir_mask,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [3:0]            i_wr_addr,
  input  logic [CFGW-1:0]       i_wr_data,
  output logic [NPADS-1:0]      o_pad_ie,
  output logic [NPADS-1:0]      o_pad_oen,
  output logic [NPADS*CFGW-1:0] o_pad_cfg,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int CW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int IW = (NPADS > 1) ? $clog2(NPADS) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(STAGGER - 1);
  localparam logic [IW-1:0] LAST = IW'(NPADS - 1);
  state_t r_state, w_state_nxt;
  logic [NPADS-1:0] r_dir, r_en, w_dir_nxt, w_en_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [NPADS*CFGW-1:0] w_cfg, w_cfg_nxt;
  logic w_we;
  assign o_wr_ready = (r_state == IDLE) || (r_state == ON);
  assign w_we = i_wr_valid && o_wr_ready;
  x7408_padseq_regfile #(.NPADS(NPADS), .CFGW(CFGW)) u_regfile (
    .i_clk(i_clk), .i_reset(i_reset), .i_we(w_we), .i_addr(i_wr_addr), .i_data(i_wr_data), .o_rdata(w_cfg)
  );
  // pad_cfg is registered from the post-write value so a write lands on the pad in the same cycle as the register
  for (genvar i = 0; i < NPADS; i++) begin : g_cfg
    assign w_cfg_nxt[i*CFGW +: CFGW] = !w_en_nxt[i] ? '0 :
      (w_we && i_wr_addr == 4'(i)) ? i_wr_data : w_cfg[i*CFGW +: CFGW];
  end
  // r_idx is the pad most recently enabled (SEQ_ON) or disabled (SEQ_OFF)
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt = r_dir;
    w_en_nxt = r_en;
    w_cnt_nxt = r_cnt;
    w_idx_nxt = r_idx;
    case (r_state)
      IDLE: if (i_start) begin
        w_state_nxt = SEQ_ON;
        w_dir_nxt = i_dir_mask;
        w_en_nxt = NPADS'(1);
        w_idx_nxt = '0;
        w_cnt_nxt = RELOAD;
      end
      SEQ_ON: if (i_stop) begin
        w_state_nxt = SEQ_OFF;
        w_en_nxt[r_idx] = 1'b0;
        w_cnt_nxt = RELOAD;
      end else if (r_idx == LAST) w_state_nxt = ON;
      else if (r_cnt == '0) begin
        w_idx_nxt = r_idx + IW'(1);
        w_en_nxt[w_idx_nxt] = 1'b1;
        w_cnt_nxt = RELOAD;
      end else w_cnt_nxt = r_cnt - CW'(1);
      ON: if (i_stop) begin
        w_state_nxt = SEQ_OFF;
        w_en_nxt[LAST] = 1'b0;
        w_idx_nxt = LAST;
        w_cnt_nxt = RELOAD;
      end
      default: if (r_idx == '0) w_state_nxt = IDLE;
      else if (r_cnt == '0) begin
        w_idx_nxt = r_idx - IW'(1);
        w_en_nxt[w_idx_nxt] = 1'b0;
        w_cnt_nxt = RELOAD;
      end else w_cnt_nxt = r_cnt - CW'(1);
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state <= IDLE;
      r_dir <= '0;
      r_en <= '0;
      r_cnt <= '0;
      r_idx <= '0;
      o_pad_ie <= '0;
      o_pad_oen <= '1;
      o_pad_cfg <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir <= w_dir_nxt;
      r_en <= w_en_nxt;
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
      o_pad_ie <= w_en_nxt & ~w_dir_nxt;
      o_pad_oen <= ~(w_en_nxt & w_dir_nxt);
      o_pad_cfg <= w_cfg_nxt;
      o_busy <= (w_state_nxt == SEQ_ON) || (w_state_nxt == SEQ_OFF);
      o_done <= w_state_nxt == ON;
    end
endmodule

// File: tb/tb_x7408_padseq.sv
// tb_x7408_padseq: directed scenarios with cycle-stamped expectations checked by a monitor
module tb_x7408_padseq;
  localparam int IE = 0, OEN = 1, CFG = 2, BUSY = 3, DONE = 4, RDY = 5;
  typedef struct {
    int c;
    int k;
    logic [95:0] v;
    string n;
  } exp_t;
  logic clk = 0, rst = 1, start = 0, stop = 0, wr_valid = 0, wr_ready, busy, done;
  logic [11:0] dir_mask = '0, pad_ie, pad_oen;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [95:0] pad_cfg;
  int cyc = 0, checks = 0, errors = 0;
  int s, t, a, b, c;
  exp_t q[$];

  x7408_padseq dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_stop(stop), .i_dir_mask(dir_mask),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_pad_ie(pad_ie), .o_pad_oen(pad_oen), .o_pad_cfg(pad_cfg), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [95:0] cv(logic [7:0] p11, logic [7:0] p3, logic [7:0] p0);
    return {p11, 56'h0, p3, 16'h0, p0};
  endfunction

  function automatic logic [95:0] pick(int k);
    case (k)
      IE: return 96'(pad_ie);
      OEN: return 96'(pad_oen);
      CFG: return pad_cfg;
      BUSY: return 96'(busy);
      DONE: return 96'(done);
      default: return 96'(wr_ready);
    endcase
  endfunction

  task automatic ex(int cc, int k, logic [95:0] v, string n);
    exp_t e;
    int p;
    e.c = cc; e.k = k; e.v = v; e.n = n;
    p = q.size();
    while (p > 0 && q[p-1].c > cc) p--;
    q.insert(p, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(int cc);
    while (cyc < cc) tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [95:0] act;
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      act = pick(e.k);
      checks++;
      if (e.c < cyc || act !== e.v) begin
        errors++;
        $display("FAIL %s at cycle %0d: got %0h expected %0h", e.n, cyc, act, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    rst = 0;
    tick();
    t = cyc;
    ex(t, IE, 0, "rst_ie"); ex(t, OEN, 'hFFF, "rst_oen"); ex(t, CFG, 0, "rst_cfg");
    ex(t, BUSY, 0, "rst_busy"); ex(t, DONE, 0, "rst_done"); ex(t, RDY, 1, "rst_rdy");
    stop = 1;
    wr_valid = 1; wr_addr = 13; wr_data = 8'h77; tick();
    stop = 0;
    wr_addr = 3; wr_data = 8'hA5; tick();
    wr_addr = 11; wr_data = 8'h3C; tick();
    wr_valid = 0;
    ex(cyc, BUSY, 0, "stop_idle_ignored");
    // enable sequence with pads 0..3 as outputs
    s = cyc;
    start = 1; dir_mask = 12'h00F; tick();
    start = 0; dir_mask = 12'h000;
    ex(s+1, IE, 0, "on_p0_ie"); ex(s+1, OEN, 'hFFE, "on_p0_oen"); ex(s+1, BUSY, 1, "on_busy");
    ex(s+1, DONE, 0, "on_done0"); ex(s+1, RDY, 0, "on_rdy0"); ex(s+2, RDY, 0, "rdy_seqon");
    ex(s+4, OEN, 'hFFE, "on_p1_not_yet"); ex(s+5, OEN, 'hFFC, "on_p1_oen");
    ex(s+12, CFG, 0, "cfg_p3_not_yet"); ex(s+13, CFG, cv(0, 8'hA5, 0), "cfg_p3_on");
    ex(s+17, IE, 'h010, "on_p4_ie"); ex(s+44, IE, 'h7F0, "on_p11_not_yet");
    ex(s+45, IE, 'hFF0, "on_all_ie"); ex(s+45, OEN, 'hFF0, "on_all_oen"); ex(s+45, DONE, 0, "done_not_yet");
    ex(s+46, DONE, 1, "done_on"); ex(s+46, BUSY, 0, "busy_on"); ex(s+46, RDY, 1, "rdy_on");
    ex(s+46, CFG, cv(8'h3C, 8'hA5, 0), "cfg_all_on");
    ex(s+47, RDY, 1, "rdy_on2"); ex(s+48, CFG, cv(8'h3C, 8'hA5, 8'h11), "cfg_write_on");
    wait_to(s+2);
    wr_valid = 1; wr_addr = 5; wr_data = 8'h55; start = 1; tick();
    wr_valid = 0; start = 0;
    wait_to(s+47);
    wr_valid = 1; wr_addr = 0; wr_data = 8'h11; tick();
    wr_valid = 0;
    // disable sequence from ON with start and stop together
    wait_to(s+50);
    t = cyc;
    start = 1; stop = 1; tick();
    start = 0; stop = 0;
    ex(t+1, IE, 'h7F0, "off_p11_ie"); ex(t+1, OEN, 'hFF0, "off_p11_oen");
    ex(t+1, CFG, cv(0, 8'hA5, 8'h11), "off_p11_cfg"); ex(t+1, BUSY, 1, "off_busy");
    ex(t+1, DONE, 0, "off_done"); ex(t+1, RDY, 0, "off_rdy");
    ex(t+44, OEN, 'hFFE, "off_p0_not_yet"); ex(t+45, OEN, 'hFFF, "off_all_oen");
    ex(t+45, IE, 0, "off_all_ie"); ex(t+45, BUSY, 1, "off_busy_last");
    ex(t+46, BUSY, 0, "off_idle_busy"); ex(t+46, RDY, 1, "off_idle_rdy");
    wait_to(t+10);
    start = 1; tick();
    start = 0;
    wait_to(t+20);
    stop = 1; tick();
    stop = 0;
    wait_to(t+47);
    // abort mid enable, all pads inputs; start wins over stop in IDLE
    a = cyc;
    start = 1; stop = 1; tick();
    start = 0; stop = 0;
    ex(a+1, IE, 'h001, "ab_p0"); ex(a+1, BUSY, 1, "ab_start_wins"); ex(a+9, IE, 'h007, "ab_p2");
    ex(a+9, OEN, 'hFFF, "ab_oen"); ex(a+11, IE, 'h003, "ab_p2_off"); ex(a+11, CFG, 'h11, "ab_cfg");
    ex(a+15, IE, 'h001, "ab_p1_off"); ex(a+18, IE, 'h001, "ab_p0_not_yet");
    ex(a+19, IE, 0, "ab_p0_off"); ex(a+19, BUSY, 1, "ab_busy_last");
    ex(a+20, BUSY, 0, "ab_idle"); ex(a+20, RDY, 1, "ab_idle_rdy");
    wait_to(a+10);
    stop = 1; tick();
    stop = 0;
    wait_to(a+22);
    // asynchronous reset mid enable
    b = cyc;
    start = 1; tick();
    start = 0;
    ex(b+5, IE, 'h003, "pre_rst_ie");
    ex(b+6, IE, 0, "arst_ie"); ex(b+6, OEN, 'hFFF, "arst_oen"); ex(b+6, CFG, 0, "arst_cfg");
    ex(b+6, BUSY, 0, "arst_busy"); ex(b+6, DONE, 0, "arst_done"); ex(b+6, RDY, 1, "arst_rdy");
    wait_to(b+6);
    rst = 1; tick();
    rst = 0; tick();
    // cfg registers must have been cleared by reset
    c = cyc;
    start = 1; tick();
    start = 0;
    ex(c+46, DONE, 1, "post_rst_done"); ex(c+46, IE, 'hFFF, "post_rst_ie"); ex(c+46, CFG, 0, "post_rst_cfg");
    wait_to(c+49);
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL unchecked expectations: got %0d left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
